// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback controller.
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEF = 32;

    localparam logic RATE_44K = 1'b0;
    localparam logic RATE_22K = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; occupancy is tracked separately from the wrapping pointers.
module sample_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SAMPLE_W = 32,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    output logic [SAMPLE_W-1:0] head_o,
    output logic [LVL_W-1:0]    level_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic                wr_en, rd_en;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rd_en = pop_i && !empty_o && !flush_i;
    assign wr_en = push_i && (!full_o || rd_en) && !flush_i;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer: buffers host samples and releases one per effective rate tick to the DAC.
module audio_playback_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                audio_starts,
    input  logic                audio_22khz,
    input  logic                end_audio_sample,
    input  logic                is_audio_sample,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                rate_tick,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                dac_valid,
    output logic                data_req,
    output logic                active,
    output logic                mode_22k,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                underrun,
    output logic                overflow
);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic                phase_q, phase_d;
    logic [SAMPLE_W-1:0] dac_data_q, dac_data_d;
    logic                dac_valid_q, dac_valid_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic                data_req_q, data_req_d;
    logic                active_q, active_d;

    logic                fifo_flush, fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                tick_eff;

    sample_fifo #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .flush_i   (fifo_flush),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .wr_data_i (sample_data),
        .head_o    (fifo_head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            mode_q      <= RATE_44K;
            phase_q     <= 1'b0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            data_req_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            data_req_q  <= data_req_d;
            active_q    <= active_d;
        end
    end

    // Next state, FIFO control and DAC register update.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        underrun_d  = 1'b0;
        overflow_d  = 1'b0;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        // In 22k mode only every other rate tick releases a sample.
        tick_eff    = rate_tick && ((mode_q == RATE_44K) || !phase_q);

        if (audio_starts) begin
            fifo_flush = 1'b1;
            mode_d     = audio_22khz;
            phase_d    = 1'b0;
            state_d    = ST_PRIME;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_PRIME: begin
                    if (is_audio_sample) begin
                        if (!fifo_full) fifo_push  = 1'b1;
                        else            overflow_d = 1'b1;
                    end
                    if (end_audio_sample) begin
                        state_d = fifo_empty ? ST_IDLE : ST_DRAIN;
                    end else if (fifo_full) begin
                        state_d = ST_PLAY;
                        phase_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (rate_tick && (mode_q == RATE_22K)) phase_d = ~phase_q;
                    if (tick_eff) begin
                        dac_valid_d = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            dac_data_d = fifo_head;
                        end else begin
                            dac_data_d = '0;
                            underrun_d = 1'b1;
                        end
                    end
                    if (is_audio_sample) begin
                        if (!fifo_full || fifo_pop) fifo_push  = 1'b1;
                        else                        overflow_d = 1'b1;
                    end
                    if (end_audio_sample) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (rate_tick && (mode_q == RATE_22K)) phase_d = ~phase_q;
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else if (tick_eff) begin
                        fifo_pop    = 1'b1;
                        dac_valid_d = 1'b1;
                        dac_data_d  = fifo_head;
                        if (fifo_level == LVL_W'(1)) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        active_d   = (state_d != ST_IDLE);
        data_req_d = ((state_q == ST_PRIME) || (state_q == ST_PLAY)) &&
                     (fifo_level < LVL_W'(DEPTH / 2));
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign data_req  = data_req_q;
    assign active    = active_q;
    assign mode_22k  = mode_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Self-checking bench for audio_playback_ctrl: directed table, corner sequences, random vs queue model.
module tb_audio_playback_ctrl;

    localparam int DEPTH = 8;
    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        audio_starts = 1'b0, audio_22khz = 1'b0, end_audio_sample = 1'b0;
    logic        is_audio_sample = 1'b0, rate_tick = 1'b0;
    logic [31:0] sample_data = '0;
    logic [31:0] dac_data;
    logic        dac_valid, data_req, active, mode_22k, underrun, overflow;
    logic [3:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    audio_playback_ctrl #(.DEPTH(DEPTH), .SAMPLE_W(32)) dut (
        .clk              (clk),
        .nreset           (nreset),
        .audio_starts     (audio_starts),
        .audio_22khz      (audio_22khz),
        .end_audio_sample (end_audio_sample),
        .is_audio_sample  (is_audio_sample),
        .sample_data      (sample_data),
        .rate_tick        (rate_tick),
        .dac_data         (dac_data),
        .dac_valid        (dac_valid),
        .data_req         (data_req),
        .active           (active),
        .mode_22k         (mode_22k),
        .fifo_level       (fifo_level),
        .underrun         (underrun),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: stream state, sample queue, rate phase and expected registered outputs.
    logic [31:0] mq[$];
    int          mst;
    bit          m22, mphase;
    logic [31:0] m_data;
    bit          m_valid, m_req, m_under, m_over;

    typedef struct {
        bit          st, r22, en, smp;
        logic [31:0] d;
        bit          tk;
        bit          ev;
        logic [31:0] ed;
        int          el;
        bit          ea, er, eu;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(bit st, bit r22, bit en, bit smp, logic [31:0] d, bit tk,
                                bit ev, logic [31:0] ed, int el, bit ea, bit er, bit eu);
        vec_t v;
        v.st = st; v.r22 = r22; v.en = en; v.smp = smp; v.d = d; v.tk = tk;
        v.ev = ev; v.ed = ed; v.el = el; v.ea = ea; v.er = er; v.eu = eu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst = M_IDLE; m22 = 0; mphase = 0;
        m_data = '0; m_valid = 0; m_req = 0; m_under = 0; m_over = 0;
    endtask

    task automatic model_step();
        int lvl;
        bit eff, popped;
        lvl = mq.size();
        m_req   = (mst == M_PRIME || mst == M_PLAY) && (lvl < DEPTH / 2);
        m_valid = 0; m_under = 0; m_over = 0; popped = 0;
        eff = rate_tick && !(m22 && mphase);
        if (audio_starts) begin
            mq.delete(); m22 = audio_22khz; mphase = 0; mst = M_PRIME;
        end else if (mst == M_PRIME) begin
            if (is_audio_sample) begin
                if (lvl < DEPTH) mq.push_back(sample_data);
                else m_over = 1;
            end
            if (end_audio_sample) mst = (lvl == 0) ? M_IDLE : M_DRAIN;
            else if (lvl == DEPTH) begin mst = M_PLAY; mphase = 0; end
        end else if (mst == M_PLAY) begin
            if (rate_tick && m22) mphase = !mphase;
            if (eff) begin
                m_valid = 1;
                if (lvl > 0) begin m_data = mq.pop_front(); popped = 1; end
                else begin m_data = '0; m_under = 1; end
            end
            if (is_audio_sample) begin
                if (lvl < DEPTH || popped) mq.push_back(sample_data);
                else m_over = 1;
            end
            if (end_audio_sample) mst = M_DRAIN;
        end else if (mst == M_DRAIN) begin
            if (rate_tick && m22) mphase = !mphase;
            if (lvl == 0) mst = M_IDLE;
            else if (eff) begin
                m_valid = 1;
                m_data = mq.pop_front();
                if (lvl == 1) mst = M_IDLE;
            end
        end
    endtask

    task automatic cyc(input bit st, input bit r22, input bit en, input bit smp,
                       input logic [31:0] d, input bit tk);
        audio_starts = st; audio_22khz = r22; end_audio_sample = en;
        is_audio_sample = smp; sample_data = d; rate_tick = tk;
        model_step();
        @(posedge clk);
        #1;
        audio_starts = 0; audio_22khz = 0; end_audio_sample = 0;
        is_audio_sample = 0; sample_data = '0; rate_tick = 0;
    endtask

    task automatic do_reset();
        nreset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        nreset = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  dac_data, 32'h0);
        chk({tag, "_valid"}, 32'(dac_valid), 32'h0);
        chk({tag, "_req"},   32'(data_req), 32'h0);
        chk({tag, "_active"},32'(active), 32'h0);
        chk({tag, "_mode"},  32'(mode_22k), 32'h0);
        chk({tag, "_level"}, 32'(fifo_level), 32'h0);
        chk({tag, "_under"}, 32'(underrun), 32'h0);
        chk({tag, "_over"},  32'(overflow), 32'h0);
    endtask

    task automatic compare_model(input int n);
        string tag;
        tag = $sformatf("rnd%0d", n);
        chk({tag, "_data"},  dac_data, m_data);
        chk({tag, "_valid"}, 32'(dac_valid), 32'(m_valid));
        chk({tag, "_req"},   32'(data_req), 32'(m_req));
        chk({tag, "_active"},32'(active), 32'(mst != M_IDLE));
        chk({tag, "_mode"},  32'(mode_22k), 32'(m22));
        chk({tag, "_level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, "_under"}, 32'(underrun), 32'(m_under));
        chk({tag, "_over"},  32'(overflow), 32'(m_over));
    endtask

    task automatic start_and_fill(input bit r22);
        cyc(1, r22, 0, 0, '0, 0);
        for (int k = 1; k <= DEPTH; k++) cyc(0, 0, 0, 1, 32'h0001_0001 * k, 0);
        cyc(0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        int pulses;
        logic [31:0] nxt;

        // 44k fill, play out in order, underrun, end with empty FIFO.
        vt[0] = mk(1, 0, 0, 0, '0, 0, 0, '0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            vt[k] = mk(0, 0, 0, 1, 32'h0001_0001 * k, 0, 0, '0, k, 1, (k <= 4), 0);
        vt[9] = mk(0, 0, 0, 0, '0, 0, 0, '0, 8, 1, 0, 0);
        for (int j = 0; j < 8; j++)
            vt[10 + j] = mk(0, 0, 0, 0, '0, 1, 1, 32'h0001_0001 * (j + 1), 7 - j, 1, (j >= 5), 0);
        vt[18] = mk(0, 0, 0, 0, '0, 1, 1, 32'h0, 0, 1, 1, 1);
        vt[19] = mk(0, 0, 0, 0, '0, 0, 0, 32'h0, 0, 1, 1, 0);
        vt[20] = mk(0, 0, 1, 0, '0, 0, 0, 32'h0, 0, 1, 1, 0);
        vt[21] = mk(0, 0, 0, 0, '0, 0, 0, 32'h0, 0, 0, 0, 0);

        model_reset();
        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 22; i++) begin
            cyc(vt[i].st, vt[i].r22, vt[i].en, vt[i].smp, vt[i].d, vt[i].tk);
            chk($sformatf("tbl%0d_valid", i), 32'(dac_valid), 32'(vt[i].ev));
            chk($sformatf("tbl%0d_data", i), dac_data, vt[i].ed);
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(vt[i].el));
            chk($sformatf("tbl%0d_active", i), 32'(active), 32'(vt[i].ea));
            chk($sformatf("tbl%0d_req", i), 32'(data_req), 32'(vt[i].er));
            chk($sformatf("tbl%0d_under", i), 32'(underrun), 32'(vt[i].eu));
        end

        // 22k: six ticks release samples on ticks 1, 3 and 5 only.
        do_reset();
        start_and_fill(1);
        chk("r22_mode", 32'(mode_22k), 32'h1);
        pulses = 0;
        for (int t = 1; t <= 6; t++) begin
            cyc(0, 0, 0, 0, '0, 1);
            chk($sformatf("r22_tick%0d_valid", t), 32'(dac_valid), 32'(t % 2));
            if (dac_valid) begin
                pulses++;
                chk($sformatf("r22_tick%0d_data", t), dac_data, 32'h0001_0001 * pulses);
            end
        end
        chk("r22_pulses", 32'(pulses), 32'd3);
        chk("r22_level", 32'(fifo_level), 32'd5);

        // Overflow on a full FIFO, then a push/pop cycle keeps the level and appends.
        do_reset();
        start_and_fill(0);
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("ovf_pulse", 32'(overflow), 32'h1);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        cyc(0, 0, 0, 1, 32'hAAAA_5555, 1);
        chk("pp_over", 32'(overflow), 32'h0);
        chk("pp_level", 32'(fifo_level), 32'd8);
        chk("pp_data", dac_data, 32'h0001_0001);
        for (int j = 2; j <= 9; j++) begin
            cyc(0, 0, 0, 0, '0, 1);
            nxt = (j == 9) ? 32'hAAAA_5555 : 32'h0001_0001 * j;
            chk($sformatf("pp_out%0d", j), dac_data, nxt);
        end

        // End of stream: later samples ignored, remaining five drain, then idle.
        do_reset();
        start_and_fill(0);
        repeat (3) cyc(0, 0, 0, 0, '0, 1);
        cyc(0, 0, 1, 0, '0, 0);
        chk("drn_req", 32'(data_req), 32'h0);
        chk("drn_active", 32'(active), 32'h1);
        cyc(0, 0, 0, 1, 32'h1234_5678, 0);
        chk("drn_ign_level", 32'(fifo_level), 32'd5);
        chk("drn_ign_over", 32'(overflow), 32'h0);
        chk("drn_ign_req", 32'(data_req), 32'h0);
        for (int t = 1; t <= 5; t++) begin
            cyc(0, 0, 0, 0, '0, 1);
            chk($sformatf("drn_t%0d_data", t), dac_data, 32'h0001_0001 * (t + 3));
            chk($sformatf("drn_t%0d_active", t), 32'(active), 32'(t < 5));
        end
        chk("drn_level", 32'(fifo_level), 32'd0);

        // Restart mid-play flushes and relatches the rate; reset mid-prime clears at once.
        do_reset();
        start_and_fill(0);
        repeat (4) cyc(0, 0, 0, 0, '0, 1);
        chk("rst_pre_level", 32'(fifo_level), 32'd4);
        cyc(1, 1, 0, 0, '0, 0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_mode", 32'(mode_22k), 32'h1);
        chk("rst_active", 32'(active), 32'h1);
        chk("rst_valid", 32'(dac_valid), 32'h0);
        cyc(0, 0, 0, 1, 32'h0000_0005, 0);
        cyc(0, 0, 0, 1, 32'h0000_0006, 0);
        chk("prime_level", 32'(fifo_level), 32'd2);
        #2;
        nreset = 0;
        model_reset();
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        nreset = 1;
        chk_all_zero("post_rst");

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 47) == 0), 1'($urandom_range(0, 1)),
                $urandom(), ($urandom_range(0, 3) == 0));
            compare_model(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
